pipeif_fetch: RTL and testbench
===============================

PIPEIF_FETCH -- requirements
Module: pipeif_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch address after reset.
REQ-002 clock  in  1  sole clock, all state updates on rising edge.
REQ-003 resetn  in  1  reset, asynchronous, active-low.
REQ-004 wpcir  in  1  decode-stage write enable; 1 = IF/ID register captures pc4/ins this edge.
REQ-005 pcsource  in  2  next-PC select from decode: 00 seq, 01 branch, 10 register, 11 jump.
REQ-006 bpc, da, jpc  in  32 each  branch target, register target, jump target.
REQ-007 imem_req  out  1  instruction-memory request, held until ack.
REQ-008 imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-009 imem_ack  in  1  one-cycle response strobe, earliest one cycle after req.
REQ-010 imem_rdata  in  32  instruction word, valid when imem_ack=1.
REQ-011 ins  out  32  held instruction; 32'h0 (nop) whenever ins_valid=0.
REQ-012 pc4  out  32  address of held instruction plus 4.
REQ-013 ins_valid  out  1  ins/pc4 carry a real instruction.

Function
REQ-014 States SHALL be IDLE, FETCH, HOLD, DISCARD, all registered.
REQ-015 IDLE SHALL last exactly one cycle after reset release, then enter FETCH with imem_req=1, imem_addr=pc.
REQ-016 FETCH, imem_ack=1, no redirect: SHALL capture imem_rdata into ins, set ins_valid=1, pc4=pc+4, enter HOLD, drop imem_req.
REQ-017 HOLD, wpcir=0: SHALL hold ins, pc4, ins_valid, pc unchanged (stall).
REQ-018 HOLD, wpcir=1, pcsource=00: SHALL set pc<=pc+4, ins_valid<=0, enter FETCH requesting new pc next cycle.
REQ-019 Redirect = wpcir=1 and pcsource!=00; target = bpc/da/jpc per pcsource.
REQ-020 Redirect in HOLD: SHALL discard held instruction (ins_valid<=0), pc<=target, enter FETCH.
REQ-021 Redirect in FETCH: SHALL latch target, enter DISCARD, keep imem_req/addr unchanged until ack.
REQ-022 DISCARD, imem_ack=1: SHALL drop rdata, pc<=latched target, enter FETCH; ins_valid stays 0.
REQ-023 Further redirect in DISCARD SHALL overwrite latched target; latest wins.
REQ-024 Redirect coincident with ack in FETCH: SHALL drop rdata, pc<=target, enter FETCH directly.
REQ-025 pcsource SHALL be ignored when wpcir=0.
REQ-026 pc arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 Throughput SHALL be one instruction per two cycles with single-cycle ack.

Reset
REQ-028 resetn=0 SHALL immediately force state=IDLE, pc=RESET_PC, imem_req=0, ins=0, pc4=0, ins_valid=0, latched target=0.
REQ-029 Reset mid-request SHALL abandon outstanding access; a later stray imem_ack SHALL be ignored outside FETCH/DISCARD.

Configuration
REQ-030 Macro PIPEIF_PERF_CNT_EN defined: 32-bit outputs cnt_fetched (increments per REQ-016 capture) and cnt_dropped (per REQ-020/022/024 discard), reset 0, wrap at 2^32.
REQ-031 Macro undefined: counters and ports absent; all other behaviour identical.

Structure
REQ-032 Package pipeif_pkg SHALL hold state enum, pcsource encodings, NOP word 32'h0, default RESET_PC.
REQ-033 Next-PC selection SHALL be sub-module pipeif_npc (combinational, pc+4/bpc/da/jpc mux); FSM and registers in pipeif_fetch.

Verification
REQ-034 Reset release, ack 1 cycle after every req, wpcir=1, pcsource=00 -> imem_addr 0,4,8,...; ins_valid pulses every second cycle; pc4 4,8,12.
REQ-035 HOLD with wpcir=0 for 5 cycles -> ins, pc4 stable, no imem_req; wpcir=1 -> next request at pc+4.
REQ-036 HOLD at pc=0x10, pcsource=11, jpc=0x400 -> ins_valid=0 next cycle, next imem_addr=0x400.
REQ-037 Request outstanding at 0x20 (ack delayed 3 cycles), pcsource=01 bpc=0x80 then pcsource=10 da=0x90 -> addr 0x20 held until ack, data dropped, next imem_addr=0x90.
REQ-038 resetn pulse during outstanding request, stray ack next cycle -> imem_req=0, ins_valid=0, fetch restarts at RESET_PC.
REQ-039 With PIPEIF_PERF_CNT_EN, run REQ-034 for 4 instructions plus REQ-036 -> cnt_fetched=5, cnt_dropped=1.

Source files
------------

// File: rtl/pipeif_pkg.sv
// Shared types and constants for the pipeline instruction-fetch slice.
// Holds the fetch FSM state enum, pcsource encodings, the NOP word, the
// default reset PC and the redirect decode helper.
package pipeif_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DISCARD = 2'd3
    } state_e;

    localparam logic [1:0]  PCSRC_SEQ        = 2'b00;
    localparam logic [1:0]  PCSRC_BRANCH     = 2'b01;
    localparam logic [1:0]  PCSRC_REG        = 2'b10;
    localparam logic [1:0]  PCSRC_JUMP       = 2'b11;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A redirect is only meaningful when decode actually advances.
    function automatic logic is_redirect(input logic wpcir, input logic [1:0] pcsource);
        return wpcir && (pcsource != PCSRC_SEQ);
    endfunction

endpackage

// File: rtl/pipeif_fetch_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
// Handshake: the master raises imem_req together with a word-aligned
// imem_addr and holds both unchanged until it samples imem_ack=1 on a rising
// edge; imem_ack is a single-cycle strobe that qualifies imem_rdata, and the
// earliest it may be sampled is the edge one cycle after imem_req rose.
interface pipeif_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pipeif_npc.sv
// Next-PC selection: sequential pc+4 or one of the decode-supplied targets.
// Purely combinational; the fetch FSM decides when the result is used.
module pipeif_npc
    import pipeif_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] da,
    input  logic [31:0] jpc,
    output logic [31:0] npc
);

    // Four-way select on the decode-stage pcsource encoding.
    always_comb begin
        npc = pc + 32'd4;
        case (pcsource)
            PCSRC_SEQ:    npc = pc + 32'd4;
            PCSRC_BRANCH: npc = bpc;
            PCSRC_REG:    npc = da;
            PCSRC_JUMP:   npc = jpc;
            default:      npc = pc + 32'd4;
        endcase
    end

endmodule

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage with IF/ID holding register.
// FSM: IDLE -> FETCH (request outstanding) -> HOLD (instruction presented
// to decode) -> FETCH ...; DISCARD waits out a request that a redirect made
// stale. Optional macro PIPEIF_PERF_CNT_EN adds fetched/dropped counters.
module pipeif_fetch
    import pipeif_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               wpcir,
    input  logic [1:0]         pcsource,
    input  logic [31:0]        bpc,
    input  logic [31:0]        da,
    input  logic [31:0]        jpc,
    pipeif_fetch_if.master     imem,
    output logic [31:0]        ins,
    output logic [31:0]        pc4,
    output logic               ins_valid,
    output state_e             dbg_state
`ifdef PIPEIF_PERF_CNT_EN
    ,
    output logic [31:0]        cnt_fetched,
    output logic [31:0]        cnt_dropped
`endif
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        req_q, req_d;
    logic [31:0] npc;
    logic        redirect;

    assign redirect = is_redirect(wpcir, pcsource);

    pipeif_npc u_npc (
        .pc       (pc_q),
        .pcsource (pcsource),
        .bpc      (bpc),
        .da       (da),
        .jpc      (jpc),
        .npc      (npc)
    );

    // Next-state and next-register values for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        ins_d   = ins_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    if (redirect) begin
                        // Data arrived for a path decode just abandoned.
                        pc_d = npc;
                    end else begin
                        ins_d   = imem.imem_rdata;
                        pc4_d   = pc_q + 32'd4;
                        valid_d = 1'b1;
                        state_d = ST_HOLD;
                        req_d   = 1'b0;
                    end
                end else if (redirect) begin
                    // The access cannot be withdrawn; remember where to go.
                    tgt_d   = npc;
                    state_d = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                if (wpcir) begin
                    pc_d    = npc;
                    ins_d   = NOP_WORD;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                    req_d   = 1'b1;
                end
            end
            ST_DISCARD: begin
                if (imem.imem_ack) begin
                    // A redirect in the ack cycle is the newest one.
                    pc_d    = redirect ? npc : tgt_q;
                    state_d = ST_FETCH;
                end else if (redirect) begin
                    tgt_d = npc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

`ifdef PIPEIF_PERF_CNT_EN
    logic [31:0] cnt_fetched_q, cnt_fetched_d;
    logic [31:0] cnt_dropped_q, cnt_dropped_d;
    logic        fetch_evt, drop_evt;

    // Count captured instructions and every discarded fetch.
    always_comb begin
        fetch_evt = (state_q == ST_FETCH) && imem.imem_ack && !redirect;
        drop_evt  = ((state_q == ST_FETCH) && imem.imem_ack && redirect) ||
                    ((state_q == ST_HOLD) && redirect) ||
                    ((state_q == ST_DISCARD) && imem.imem_ack);
        cnt_fetched_d = cnt_fetched_q + {31'd0, fetch_evt};
        cnt_dropped_d = cnt_dropped_q + {31'd0, drop_evt};
    end

    assign cnt_fetched = cnt_fetched_q;
    assign cnt_dropped = cnt_dropped_q;
`endif

    // State and output registers; reset abandons any outstanding access.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            tgt_q         <= 32'h0;
            ins_q         <= NOP_WORD;
            pc4_q         <= 32'h0;
            valid_q       <= 1'b0;
            req_q         <= 1'b0;
`ifdef PIPEIF_PERF_CNT_EN
            cnt_fetched_q <= 32'h0;
            cnt_dropped_q <= 32'h0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            ins_q         <= ins_d;
            pc4_q         <= pc4_d;
            valid_q       <= valid_d;
            req_q         <= req_d;
`ifdef PIPEIF_PERF_CNT_EN
            cnt_fetched_q <= cnt_fetched_d;
            cnt_dropped_q <= cnt_dropped_d;
`endif
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign ins            = ins_q;
    assign pc4            = pc4_q;
    assign ins_valid      = valid_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_pipeif_fetch.sv
// Testbench for pipeif_fetch: a latency-programmable memory responder plus a
// transaction-level reference (expected fetch address, expected delivered
// word and pc4, expected counter totals).
`timescale 1ns/1ps
module tb_pipeif_fetch;
    import pipeif_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    // ---------------- clock / reset / DUT ----------------
    logic        clock    = 1'b0;
    logic        resetn   = 1'b0;
    logic        wpcir    = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc      = 32'h0;
    logic [31:0] da       = 32'h0;
    logic [31:0] jpc      = 32'h0;
    logic [31:0] ins;
    logic [31:0] pc4;
    logic        ins_valid;
    state_e      dbg_state;
`ifdef PIPEIF_PERF_CNT_EN
    logic [31:0] cnt_fetched;
    logic [31:0] cnt_dropped;
`endif

    pipeif_fetch_if imem_bus ();

    pipeif_fetch #(.RESET_PC(RST_PC)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .wpcir     (wpcir),
        .pcsource  (pcsource),
        .bpc       (bpc),
        .da        (da),
        .jpc       (jpc),
        .imem      (imem_bus),
        .ins       (ins),
        .pc4       (pc4),
        .ins_valid (ins_valid),
        .dbg_state (dbg_state)
`ifdef PIPEIF_PERF_CNT_EN
        ,
        .cnt_fetched (cnt_fetched),
        .cnt_dropped (cnt_dropped)
`endif
    );

    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;
    int          exp_fetched;
    int          exp_dropped;
    logic [31:0] obs_req_q[$];
    logic [31:0] last_rdata = 32'h0;

    // ---------------- memory responder ----------------
    int          mem_lat   = 0;
    int          wait_cnt  = 0;
    bit          in_req    = 1'b0;
    bit          stray_ack = 1'b0;
    logic [31:0] cur_addr  = 32'h0;

    initial begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
    end

    // Memory model: ack mem_lat cycles after a request is first seen.
    always @(negedge clock) begin
        if (!resetn) begin
            imem_bus.imem_ack = 1'b0;
            in_req            = 1'b0;
            wait_cnt          = 0;
        end else if (stray_ack) begin
            imem_bus.imem_ack   = 1'b1;
            imem_bus.imem_rdata = $urandom;
            stray_ack           = 1'b0;
        end else if (imem_bus.imem_req) begin
            if (!in_req) begin
                in_req   = 1'b1;
                wait_cnt = 0;
                cur_addr = imem_bus.imem_addr;
                obs_req_q.push_back(cur_addr);
            end else begin
                tests++;
                if (imem_bus.imem_addr !== cur_addr) begin
                    fails++;
                    $display("FAIL addr_stable: imem_addr=%h required %h", imem_bus.imem_addr, cur_addr);
                end
            end
            if (wait_cnt >= mem_lat) begin
                last_rdata          = $urandom;
                imem_bus.imem_ack   = 1'b1;
                imem_bus.imem_rdata = last_rdata;
                in_req              = 1'b0;
            end else begin
                imem_bus.imem_ack   = 1'b0;
                imem_bus.imem_rdata = $urandom;
                wait_cnt++;
            end
        end else begin
            imem_bus.imem_ack   = 1'b0;
            imem_bus.imem_rdata = $urandom;
            in_req              = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_targets(input logic [1:0] act, input logic [31:0] tgt);
        bpc = $urandom & 32'hFFFF_FFFC;
        da  = $urandom & 32'hFFFF_FFFC;
        jpc = $urandom & 32'hFFFF_FFFC;
        case (act)
            PCSRC_BRANCH: bpc = tgt;
            PCSRC_REG:    da  = tgt;
            PCSRC_JUMP:   jpc = tgt;
            default:      ;
        endcase
    endtask

    task automatic do_reset();
        wpcir    = 1'b0;
        pcsource = 2'b00;
        resetn   = 1'b0;
        mem_lat  = 0;
        @(negedge clock);
        @(posedge clock);
        #1;
        obs_req_q.delete();
        stray_ack   = 1'b0;
        exp_pc      = RST_PC;
        exp_fetched = 0;
        exp_dropped = 0;
        resetn      = 1'b1;
    endtask

    task automatic wait_request(output logic [31:0] addr, output bit ok);
        addr = 32'hx;
        ok   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (obs_req_q.size() > 0) break;
            step();
        end
        if (obs_req_q.size() > 0) begin
            addr = obs_req_q.pop_front();
            ok   = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (ins_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // One instruction: fetch at exp_pc, stall, then release with act/tgt.
    task automatic run_instr(input int lat, input int stall, input logic [1:0] act, input logic [31:0] tgt);
        logic [31:0] a;
        logic [31:0] h_ins;
        logic [31:0] h_pc4;
        bit          ok;
        mem_lat  = lat;
        wpcir    = 1'b0;
        pcsource = 2'($urandom_range(0, 3));
        set_targets(2'b00, 32'h0);
        wait_request(a, ok);
        tests++;
        if (!ok || a !== exp_pc) begin
            fails++;
            $display("FAIL req_addr: imem_addr=%h seen=%0d required %h", a, ok, exp_pc);
        end
        wait_valid(ok);
        tests++;
        if (!ok || ins !== last_rdata || pc4 !== exp_pc + 32'd4) begin
            fails++;
            $display("FAIL capture: valid=%0d ins=%h pc4=%h required ins=%h pc4=%h",
                     ok, ins, pc4, last_rdata, exp_pc + 32'd4);
        end
        exp_fetched++;
        h_ins = ins;
        h_pc4 = pc4;
        for (int s = 0; s < stall; s++) begin
            wpcir    = 1'b0;
            pcsource = 2'($urandom_range(0, 3));
            set_targets(2'b00, 32'h0);
            step();
            tests++;
            if (ins_valid !== 1'b1 || ins !== h_ins || pc4 !== h_pc4 || imem_bus.imem_req !== 1'b0) begin
                fails++;
                $display("FAIL stall: valid=%0d ins=%h pc4=%h req=%0d required 1 %h %h 0",
                         ins_valid, ins, pc4, imem_bus.imem_req, h_ins, h_pc4);
            end
        end
        wpcir    = 1'b1;
        pcsource = act;
        set_targets(act, tgt);
        step();
        wpcir = 1'b0;
        tests++;
        if (ins_valid !== 1'b0 || ins !== 32'h0 || imem_bus.imem_req !== 1'b1) begin
            fails++;
            $display("FAIL release: valid=%0d ins=%h req=%0d required 0 00000000 1",
                     ins_valid, ins, imem_bus.imem_req);
        end
        if (act == PCSRC_SEQ) begin
            exp_pc = exp_pc + 32'd4;
        end else begin
            exp_pc = tgt;
            exp_dropped++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        resetn = 1'b0;
        #2;
        tests++;
        if (imem_bus.imem_req !== 1'b0 || ins !== 32'h0 || pc4 !== 32'h0 || ins_valid !== 1'b0 ||
            dbg_state !== ST_IDLE || imem_bus.imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL reset_values: req=%0d ins=%h pc4=%h valid=%0d state=%0d addr=%h",
                     imem_bus.imem_req, ins, pc4, ins_valid, dbg_state, imem_bus.imem_addr);
        end
`ifdef PIPEIF_PERF_CNT_EN
        tests++;
        if (cnt_fetched !== 32'h0 || cnt_dropped !== 32'h0) begin
            fails++;
            $display("FAIL reset_counters: fetched=%0d dropped=%0d required 0 0", cnt_fetched, cnt_dropped);
        end
`endif
        do_reset();
        tests++;
        if (dbg_state !== ST_IDLE || imem_bus.imem_req !== 1'b0) begin
            fails++;
            $display("FAIL idle_cycle: state=%0d req=%0d required IDLE 0", dbg_state, imem_bus.imem_req);
        end
        step();
        tests++;
        if (dbg_state !== ST_FETCH || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL first_req: state=%0d req=%0d addr=%h required FETCH 1 %h",
                     dbg_state, imem_bus.imem_req, imem_bus.imem_addr, RST_PC);
        end
    endtask

    task automatic test_throughput();
        bit ok;
        do_reset();
        mem_lat  = 0;
        wpcir    = 1'b1;
        pcsource = PCSRC_SEQ;
        wait_valid(ok);
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (ins_valid !== 1'b1 || pc4 !== RST_PC + 32'(4 * (k + 1)) || ins !== last_rdata) begin
                fails++;
                $display("FAIL tput_valid[%0d]: valid=%0d pc4=%h ins=%h required 1 %h %h",
                         k, ins_valid, pc4, ins, RST_PC + 32'(4 * (k + 1)), last_rdata);
            end
            step();
            tests++;
            if (ins_valid !== 1'b0) begin
                fails++;
                $display("FAIL tput_gap[%0d]: valid=%0d required 0", k, ins_valid);
            end
            step();
        end
        wpcir = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tests++;
            if (k >= obs_req_q.size() || obs_req_q[k] !== RST_PC + 32'(4 * k)) begin
                fails++;
                $display("FAIL tput_addr[%0d]: seen=%0d required %h", k, obs_req_q.size(), RST_PC + 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        run_instr(0, 5, PCSRC_SEQ, 32'h0);
        run_instr(1, 0, PCSRC_SEQ, 32'h0);
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
    endtask

    task automatic test_hold_jump();
        do_reset();
        run_instr(0, 0, PCSRC_JUMP, 32'h0000_0010);
        run_instr(0, 1, PCSRC_JUMP, 32'h0000_0400);
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
    endtask

    task automatic test_redirect_in_flight();
        logic [31:0] a;
        bit          ok;
        do_reset();
        run_instr(0, 0, PCSRC_JUMP, 32'h0000_0020);
        mem_lat = 3;
        wait_request(a, ok);
        tests++;
        if (!ok || a !== 32'h0000_0020) begin
            fails++;
            $display("FAIL flight_req: imem_addr=%h required 00000020", a);
        end
        wpcir    = 1'b1;
        pcsource = PCSRC_BRANCH;
        set_targets(PCSRC_BRANCH, 32'h0000_0080);
        step();
        tests++;
        if (dbg_state !== ST_DISCARD || imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== 32'h0000_0020) begin
            fails++;
            $display("FAIL flight_discard: state=%0d req=%0d addr=%h required DISCARD 1 00000020",
                     dbg_state, imem_bus.imem_req, imem_bus.imem_addr);
        end
        pcsource = PCSRC_REG;
        set_targets(PCSRC_REG, 32'h0000_0090);
        step();
        wpcir = 1'b0;
        for (int i = 0; i < 10 && obs_req_q.size() == 0; i++) begin
            tests++;
            if (ins_valid !== 1'b0) begin
                fails++;
                $display("FAIL flight_drop: valid=%0d required 0", ins_valid);
            end
            step();
        end
        exp_dropped++;
        exp_pc = 32'h0000_0090;
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
    endtask

    task automatic test_redirect_on_ack();
        logic [31:0] a;
        logic [31:0] t;
        bit          ok;
        do_reset();
        mem_lat = 0;
        wait_request(a, ok);
        wait_valid(ok);
        exp_fetched++;
        wpcir    = 1'b1;
        pcsource = PCSRC_SEQ;
        step();
        t        = $urandom & 32'hFFFF_FFFC;
        pcsource = PCSRC_JUMP;
        set_targets(PCSRC_JUMP, t);
        step();
        wpcir = 1'b0;
        tests++;
        if (ins_valid !== 1'b0 || dbg_state !== ST_FETCH || imem_bus.imem_req !== 1'b1) begin
            fails++;
            $display("FAIL ack_redirect: valid=%0d state=%0d req=%0d required 0 FETCH 1",
                     ins_valid, dbg_state, imem_bus.imem_req);
        end
        wait_request(a, ok);
        tests++;
        if (!ok || a !== RST_PC + 32'd4) begin
            fails++;
            $display("FAIL ack_redirect_req: imem_addr=%h required %h", a, RST_PC + 32'd4);
        end
        exp_dropped++;
        exp_pc = t;
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
    endtask

    task automatic test_wrap();
        do_reset();
        run_instr(0, 0, PCSRC_JUMP, 32'hFFFF_FFFC);
        run_instr(2, 0, PCSRC_SEQ, 32'h0);
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
    endtask

    task automatic test_reset_midflight();
        logic [31:0] a;
        bit          ok;
        do_reset();
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
        mem_lat = 3;
        wait_request(a, ok);
        #2;
        resetn = 1'b0;
        #1;
        tests++;
        if (imem_bus.imem_req !== 1'b0 || ins_valid !== 1'b0 || ins !== 32'h0 ||
            dbg_state !== ST_IDLE || imem_bus.imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL midreset: req=%0d valid=%0d ins=%h state=%0d addr=%h",
                     imem_bus.imem_req, ins_valid, ins, dbg_state, imem_bus.imem_addr);
        end
        @(negedge clock);
        @(posedge clock);
        #1;
        obs_req_q.delete();
        exp_pc      = RST_PC;
        exp_fetched = 0;
        exp_dropped = 0;
        mem_lat     = 0;
        resetn      = 1'b1;
        stray_ack   = 1'b1;
        step();
        tests++;
        if (dbg_state !== ST_FETCH || ins_valid !== 1'b0 || imem_bus.imem_addr !== RST_PC) begin
            fails++;
            $display("FAIL stray_ack: state=%0d valid=%0d addr=%h required FETCH 0 %h",
                     dbg_state, ins_valid, imem_bus.imem_addr, RST_PC);
        end
        run_instr(0, 0, PCSRC_SEQ, 32'h0);
    endtask

    task automatic test_random();
        logic [1:0] act;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            act = ($urandom_range(0, 1) == 0) ? PCSRC_SEQ : 2'($urandom_range(1, 3));
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), act,
                      $urandom & 32'hFFFF_FFFC);
        end
`ifdef PIPEIF_PERF_CNT_EN
        tests++;
        if (cnt_fetched !== 32'(exp_fetched) || cnt_dropped !== 32'(exp_dropped)) begin
            fails++;
            $display("FAIL rand_counters: fetched=%0d dropped=%0d required %0d %0d",
                     cnt_fetched, cnt_dropped, exp_fetched, exp_dropped);
        end
`endif
    endtask

`ifdef PIPEIF_PERF_CNT_EN
    task automatic test_counters();
        do_reset();
        for (int n = 0; n < 4; n++) run_instr(0, 0, PCSRC_SEQ, 32'h0);
        run_instr(0, 0, PCSRC_JUMP, 32'h0000_0400);
        tests++;
        if (cnt_fetched !== 32'd5 || cnt_dropped !== 32'd1) begin
            fails++;
            $display("FAIL counters: fetched=%0d dropped=%0d required 5 1", cnt_fetched, cnt_dropped);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_throughput();
        test_stall();
        test_hold_jump();
        test_redirect_in_flight();
        test_redirect_on_ack();
        test_wrap();
        test_reset_midflight();
        test_random();
`ifdef PIPEIF_PERF_CNT_EN
        test_counters();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
